// File: rtl/axi_grid_pkg.sv
// Shared types for the AXI grid router input port: port enum, flit entry, FSM state
// and the dimension-ordered route function.
package axi_grid_pkg;

    localparam int unsigned NUM_GRID_PORTS = 5;
    localparam int unsigned GRID_FLIT_W    = 64;
    localparam int unsigned GRID_COORD_W   = 8;

    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        NORTH = 3'd1,
        EAST  = 3'd2,
        SOUTH = 3'd3,
        WEST  = 3'd4
    } grid_port_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } route_state_e;

    typedef struct packed {
        logic                   last;
        logic [GRID_FLIT_W-1:0] payload;
    } grid_flit_t;

    // X first, then Y; unsigned comparison, destinations assumed legal
    function automatic grid_port_e xy_route(input logic [GRID_COORD_W-1:0] dst_x,
                                            input logic [GRID_COORD_W-1:0] dst_y,
                                            input logic [GRID_COORD_W-1:0] my_x,
                                            input logic [GRID_COORD_W-1:0] my_y);
        grid_port_e port;
        if (dst_x > my_x)      port = EAST;
        else if (dst_x < my_x) port = WEST;
        else if (dst_y > my_y) port = NORTH;
        else if (dst_y < my_y) port = SOUTH;
        else                   port = LOCAL;
        return port;
    endfunction

endpackage

// File: rtl/axi_grid_flit_fifo.sv
// DEPTH-entry registered flit FIFO (no bypass) with valid/ready on both sides.
module axi_grid_flit_fifo
    import axi_grid_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  grid_flit_t                   wr_data_i,
    input  logic                         wr_valid_i,
    output logic                         wr_ready_o,
    output grid_flit_t                   rd_data_o,
    output logic                         rd_valid_o,
    input  logic                         rd_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    grid_flit_t             mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]       count_q,  count_d;
    logic                   push, pop;

    // Full refuses a push even when a pop happens in the same cycle
    assign wr_ready_o  = arst_ni && (count_q != OCC_W'(DEPTH));
    assign rd_valid_o  = (count_q != OCC_W'(0));
    assign rd_data_o   = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;

    assign push = wr_valid_i && wr_ready_o;
    assign pop  = rd_valid_o && rd_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + OCC_W'(1);
        else if (pop && !push) count_d = count_q - OCC_W'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; contents are only observed behind a valid count
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/axi_grid_route_port.sv
// Router input port: buffers XNI flits, routes X-then-Y from the head flit and holds
// the route (wormhole) until the tail leaves.
module axi_grid_route_port
    import axi_grid_pkg::*;
#(
    parameter int unsigned FLIT_W  = 64,
    parameter int unsigned COORD_W = 3,
    parameter int unsigned X_ID    = 0,
    parameter int unsigned Y_ID    = 0,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                         clk_i,
    input  logic                         arst_ni,
    input  logic [FLIT_W-1:0]            in_flit_i,
    input  logic                         in_last_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    output logic [FLIT_W-1:0]            out_flit_o,
    output logic                         out_last_o,
    output logic [NUM_GRID_PORTS-1:0]    out_valid_o,
    input  logic [NUM_GRID_PORTS-1:0]    out_ready_i,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    grid_flit_t    wr_entry, rd_entry;
    logic          fifo_valid;
    logic          pop_c;
    grid_port_e    route_c, route_q, route_d;
    route_state_e  state_q, state_d;
    logic [GRID_COORD_W-1:0] dst_x, dst_y;

    assign wr_entry.last    = in_last_i;
    assign wr_entry.payload = GRID_FLIT_W'(in_flit_i);

    axi_grid_flit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .arst_ni     (arst_ni),
        .wr_data_i   (wr_entry),
        .wr_valid_i  (in_valid_i),
        .wr_ready_o  (in_ready_o),
        .rd_data_o   (rd_entry),
        .rd_valid_o  (fifo_valid),
        .rd_ready_i  (pop_c),
        .occupancy_o (occupancy_o)
    );

    assign out_flit_o = FLIT_W'(rd_entry.payload);
    assign out_last_o = rd_entry.last;

    assign dst_x = GRID_COORD_W'(out_flit_o[COORD_W-1:0]);
    assign dst_y = GRID_COORD_W'(out_flit_o[2*COORD_W-1:COORD_W]);

    // Coordinates are decoded only while the head flit sits at the FIFO output
    assign route_c = (state_q == ST_IDLE)
                   ? xy_route(dst_x, dst_y, GRID_COORD_W'(X_ID), GRID_COORD_W'(Y_ID))
                   : route_q;

    assign out_valid_o = (arst_ni && fifo_valid)
                       ? (NUM_GRID_PORTS'(1) << route_c)
                       : '0;

    assign pop_c = |(out_valid_o & out_ready_i);

    always_comb begin
        state_d = state_q;
        route_d = route_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pop_c && !out_last_o) begin
                    state_d = ST_LOCKED;
                    route_d = route_c;
                end
            end
            ST_LOCKED: begin
                if (pop_c && out_last_o) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q <= ST_IDLE;
            route_q <= LOCAL;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

endmodule

// File: tb/tb_axi_grid_route_port.sv
// Directed bench for axi_grid_route_port at node (2,2), DEPTH=4, ending with a
// randomized packet stream checked against a queue model.
module tb_axi_grid_route_port;

    localparam int unsigned FLIT_W = 64;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              arst_ni;
    logic [FLIT_W-1:0] in_flit;
    logic              in_last;
    logic              in_valid;
    logic              in_ready;
    logic [FLIT_W-1:0] out_flit;
    logic              out_last;
    logic [4:0]        out_valid;
    logic [4:0]        out_ready;
    logic [2:0]        occupancy;

    int nvec = 0;
    int nerr = 0;

    typedef struct packed {
        logic [63:0] flit;
        logic        last;
        logic [2:0]  route;
    } ent_t;

    ent_t stim[$];
    ent_t q[$];

    always #5 clk = ~clk;

    axi_grid_route_port #(
        .FLIT_W  (64),
        .COORD_W (3),
        .X_ID    (2),
        .Y_ID    (2),
        .DEPTH   (DEPTH)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .in_flit_i   (in_flit),
        .in_last_i   (in_last),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_flit_o  (out_flit),
        .out_last_o  (out_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .occupancy_o (occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] mk(input logic [2:0] x, input logic [2:0] y,
                                       input logic [57:0] tag);
        return {tag, y, x};
    endfunction

    // Reference route for node (2,2): index into [LOCAL,NORTH,EAST,SOUTH,WEST]
    function automatic logic [2:0] ref_route(input logic [2:0] x, input logic [2:0] y);
        if (x > 3'd2) return 3'd2;
        if (x < 3'd2) return 3'd4;
        if (y > 3'd2) return 3'd1;
        if (y < 3'd2) return 3'd3;
        return 3'd0;
    endfunction

    function automatic logic [4:0] onehot(input logic [2:0] idx);
        logic [4:0] one;
        one = 5'd1;
        return one << idx;
    endfunction

    task automatic push(input logic [63:0] f, input logic l);
        in_flit  = f;
        in_last  = l;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] pkt [3];
        logic [63:0] held;
        int          acc;
        int          idx;
        int          cyc;
        logic        do_push, do_pop;

        // Reset with in_valid held high
        arst_ni   = 1'b0;
        in_valid  = 1'b1;
        in_flit   = mk(3'd5, 3'd1, 58'h3ff);
        in_last   = 1'b1;
        out_ready = 5'b11111;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        step();
        step();
        chk("rst_in_ready_2", 64'(in_ready), 64'd0);
        chk("rst_out_valid_2", 64'(out_valid), 64'd0);
        arst_ni   = 1'b1;
        in_valid  = 1'b0;
        out_ready = 5'b00000;
        #1;
        chk("rel_in_ready", 64'(in_ready), 64'd1);
        chk("rel_occ", 64'(occupancy), 64'd0);
        step();
        chk("rel_out_valid", 64'(out_valid), 64'd0);

        // Single-flit packet to (5,1) goes EAST
        push(mk(3'd5, 3'd1, 58'h11), 1'b1);
        chk("single_valid", 64'(out_valid), 64'h04);
        chk("single_flit", out_flit, mk(3'd5, 3'd1, 58'h11));
        chk("single_last", 64'(out_last), 64'd1);
        out_ready = 5'b00100;
        step();
        out_ready = 5'b00000;
        chk("single_drain_occ", 64'(occupancy), 64'd0);
        chk("single_drain_valid", 64'(out_valid), 64'd0);

        // 3-flit packet to (2,0): body coordinate bits must not re-route
        pkt[0] = mk(3'd2, 3'd0, 58'h21);
        pkt[1] = mk(3'd7, 3'd7, 58'h22);
        pkt[2] = mk(3'd7, 3'd7, 58'h23);
        push(pkt[0], 1'b0);
        push(pkt[1], 1'b0);
        push(pkt[2], 1'b1);
        chk("worm_occ", 64'(occupancy), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("worm_valid_%0d", i), 64'(out_valid), 64'h08);
            chk($sformatf("worm_flit_%0d", i), out_flit, pkt[i]);
            chk($sformatf("worm_last_%0d", i), 64'(out_last), 64'(i == 2));
            out_ready = 5'b11010 | 5'b01000;
            step();
            out_ready = 5'b00000;
        end
        chk("worm_empty", 64'(occupancy), 64'd0);
        push(mk(3'd7, 3'd7, 58'h24), 1'b1);
        chk("worm_reroute", 64'(out_valid), 64'h04);
        out_ready = 5'b00100;
        step();
        out_ready = 5'b00000;

        // LOCAL packet held under backpressure on its own port
        held = mk(3'd2, 3'd2, 58'h31);
        push(held, 1'b1);
        out_ready = 5'b11110;
        for (int i = 0; i < 10; i++) begin
            chk("hold_valid", 64'(out_valid), 64'h01);
            chk("hold_flit", out_flit, held);
            chk("hold_occ", 64'(occupancy), 64'd1);
            step();
        end
        out_ready = 5'b00001;
        step();
        out_ready = 5'b00000;
        chk("hold_drain", 64'(occupancy), 64'd0);

        // Fill: 6 attempts, 4 accepted
        acc      = 0;
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_flit = mk(3'd2, 3'd2, 58'(16'h100 + acc));
            #1;
            chk($sformatf("fill_ready_%0d", i), 64'(in_ready), 64'(acc < 4));
            step();
            if (acc < 4) acc++;
        end
        chk("fill_occ", 64'(occupancy), 64'd4);
        chk("fill_ready_full", 64'(in_ready), 64'd0);

        // Full with simultaneous push and pop: push refused
        in_flit   = mk(3'd2, 3'd2, 58'h1ff);
        out_ready = 5'b00001;
        #1;
        chk("full_pp_ready", 64'(in_ready), 64'd0);
        chk("full_pp_head", out_flit, mk(3'd2, 3'd2, 58'h100));
        step();
        in_valid  = 1'b0;
        out_ready = 5'b00000;
        chk("full_pp_occ", 64'(occupancy), 64'd3);
        chk("full_pp_ready_after", 64'(in_ready), 64'd1);
        out_ready = 5'b00001;
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("fill_order_%0d", i), out_flit, mk(3'd2, 3'd2, 58'(16'h100 + i)));
            step();
        end
        out_ready = 5'b00000;
        chk("fill_drained", 64'(occupancy), 64'd0);

        // Randomized stream of 20 packets under random ready
        for (int p = 0; p < 20; p++) begin
            logic [2:0] x, y, r;
            int len;
            len = $urandom_range(1, 3);
            x   = 3'($urandom_range(0, 7));
            y   = 3'($urandom_range(0, 7));
            r   = ref_route(x, y);
            for (int f = 0; f < len; f++) begin
                ent_t e;
                e.flit  = (f == 0) ? mk(x, y, 58'({$urandom, $urandom}))
                                   : {$urandom, $urandom};
                e.last  = (f == len - 1);
                e.route = r;
                stim.push_back(e);
            end
        end
        idx = 0;
        cyc = 0;
        while ((idx < stim.size() || q.size() != 0) && cyc < 3000) begin
            chk("rnd_occ", 64'(occupancy), 64'(q.size()));
            if (q.size() != 0) begin
                chk("rnd_valid", 64'(out_valid), 64'(onehot(q[0].route)));
                chk("rnd_flit", out_flit, q[0].flit);
                chk("rnd_last", 64'(out_last), 64'(q[0].last));
            end else begin
                chk("rnd_valid_idle", 64'(out_valid), 64'd0);
            end
            out_ready = 5'($urandom);
            do_pop    = (q.size() != 0) && out_ready[q[0].route];
            in_valid  = (idx < stim.size()) && ($urandom_range(0, 3) != 0);
            if (idx < stim.size()) begin
                in_flit = stim[idx].flit;
                in_last = stim[idx].last;
            end
            do_push = in_valid && (q.size() < DEPTH);
            #1;
            chk("rnd_ready", 64'(in_ready), 64'(q.size() < DEPTH));
            step();
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                q.push_back(stim[idx]);
                idx++;
            end
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 5'b00000;
        nvec++;
        assert (cyc < 3000) else begin
            nerr++;
            $error("FAIL rnd_timeout: observed %0d cycles expected < 3000", cyc);
        end
        #1;
        chk("rnd_final_occ", 64'(occupancy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
